// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter
//
// Shares one BurstRAM between two cache-side clients. Round-robin grant,
// held until the owner's burst completes. Grant is registered. RAM command
// signals are muxed combinationally from the owner (client 0 when idle).
//
// Handshake: cN_req is a level request. cN_gnt marks ownership. While
// granted and in GRANT, one cN_cmd_en pulse launches the burst and reaches
// br_cmd_en in the same cycle. Strobes from a non-owner, or outside GRANT,
// are dropped.
//
// Ports
//   clk, rst                  clock, synchronous active-low reset
//   cN_req / cN_gnt           ownership request / grant (N = 0, 1)
//   cN_cmd, cN_cmd_en         burst command (0 read, 1 write) and strobe
//   cN_addr, cN_wr_data       burst address and write beat
//   cN_data_mask              byte mask, passed through unchanged
//   cN_rd_data(_valid)        read beat (broadcast) / valid (owner only)
//   cN_busy                   br_busy or not granted
//   br_*                      RAM command and response side
//   dbg_state                 FSM state (0 IDLE, 1 GRANT, 2 READ, 3 WRITE)
//
// Optional macro ARBITER_STATS_EN adds 32-bit counters stat_grants_c0,
// stat_grants_c1 and stat_conflicts, reachable hierarchically.

module burst_ram_arbiter #(
   parameter int DEPTH_BITWIDTH = 4,
   parameter int DATA_BITWIDTH  = 64,
   parameter int BURST_COUNT    = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   // client 0
   input  logic                         c0_req,
   output logic                         c0_gnt,
   input  logic                         c0_cmd,
   input  logic                         c0_cmd_en,
   input  logic [DEPTH_BITWIDTH-1:0]    c0_addr,
   input  logic [DATA_BITWIDTH-1:0]     c0_wr_data,
   input  logic [DATA_BITWIDTH/8-1:0]   c0_data_mask,
   output logic [DATA_BITWIDTH-1:0]     c0_rd_data,
   output logic                         c0_rd_data_valid,
   output logic                         c0_busy,
   // client 1
   input  logic                         c1_req,
   output logic                         c1_gnt,
   input  logic                         c1_cmd,
   input  logic                         c1_cmd_en,
   input  logic [DEPTH_BITWIDTH-1:0]    c1_addr,
   input  logic [DATA_BITWIDTH-1:0]     c1_wr_data,
   input  logic [DATA_BITWIDTH/8-1:0]   c1_data_mask,
   output logic [DATA_BITWIDTH-1:0]     c1_rd_data,
   output logic                         c1_rd_data_valid,
   output logic                         c1_busy,
   // RAM side
   output logic                         br_cmd,
   output logic                         br_cmd_en,
   output logic [DEPTH_BITWIDTH-1:0]    br_addr,
   output logic [DATA_BITWIDTH-1:0]     br_wr_data,
   output logic [DATA_BITWIDTH/8-1:0]   br_data_mask,
   input  logic [DATA_BITWIDTH-1:0]     br_rd_data,
   input  logic                         br_rd_data_valid,
   input  logic                         br_busy,
   // debug
   output logic [1:0]                   dbg_state
);

   localparam int CNT_W = $clog2(BURST_COUNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(BURST_COUNT);
   localparam logic [CNT_W-1:0] CNT_LAST_RD = CNT_W'(BURST_COUNT - 1);
   // The write command cycle carries beat 1, so WRITE only spans the rest.
   localparam logic [CNT_W-1:0] CNT_LAST_WR = CNT_W'(BURST_COUNT - 2);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_READ  = 2'd2,
      ST_WRITE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_owner_q, last_owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             c0_gnt_q, c1_gnt_q;

   logic             sel;
   logic             own_req;
   logic             own_cmd;
   logic             own_cmd_en;
   logic             arb_fire;
   logic             winner;
   logic [CNT_W-1:0] cnt_inc;

   // Mux select: the owner while a burst is in progress, client 0 when idle.
   assign sel        = (state_q == ST_IDLE) ? 1'b0 : owner_q;
   assign own_req    = sel ? c1_req    : c0_req;
   assign own_cmd    = sel ? c1_cmd    : c0_cmd;
   assign own_cmd_en = sel ? c1_cmd_en : c0_cmd_en;

   assign arb_fire = (state_q == ST_IDLE) && !br_busy && (c0_req || c1_req);
   // On a tie the client that did not own the RAM last time wins.
   assign winner   = (c0_req && c1_req) ? ~last_owner_q : c1_req;

   // Saturating increment; the counter never wraps.
   assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      cnt_d        = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_fire) begin
               state_d      = ST_GRANT;
               owner_d      = winner;
               last_owner_d = winner;
            end
         end
         ST_GRANT: begin
            if (own_cmd_en) begin
               state_d = own_cmd ? ST_WRITE : ST_READ;
               cnt_d   = '0;
            end else if (!own_req) begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            if (br_rd_data_valid) begin
               cnt_d = cnt_inc;
               if (cnt_q == CNT_LAST_RD) state_d = ST_IDLE;
            end
         end
         ST_WRITE: begin
            cnt_d = cnt_inc;
            if (cnt_q == CNT_LAST_WR) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         cnt_q        <= '0;
         c0_gnt_q     <= 1'b0;
         c1_gnt_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         cnt_q        <= cnt_d;
         c0_gnt_q     <= (state_d != ST_IDLE) && !owner_d;
         c1_gnt_q     <= (state_d != ST_IDLE) &&  owner_d;
      end
   end

   assign c0_gnt = c0_gnt_q;
   assign c1_gnt = c1_gnt_q;

   assign br_cmd       = own_cmd;
   assign br_cmd_en    = (state_q == ST_GRANT) && own_cmd_en;
   assign br_addr      = sel ? c1_addr      : c0_addr;
   assign br_wr_data   = sel ? c1_wr_data   : c0_wr_data;
   assign br_data_mask = sel ? c1_data_mask : c0_data_mask;

   assign c0_rd_data       = br_rd_data;
   assign c1_rd_data       = br_rd_data;
   assign c0_rd_data_valid = br_rd_data_valid && (state_q == ST_READ) && !owner_q;
   assign c1_rd_data_valid = br_rd_data_valid && (state_q == ST_READ) &&  owner_q;

   assign c0_busy = br_busy || !c0_gnt_q;
   assign c1_busy = br_busy || !c1_gnt_q;

   assign dbg_state = state_q;

`ifdef ARBITER_STATS_EN
   logic [31:0] stat_grants_c0;
   logic [31:0] stat_grants_c1;
   logic [31:0] stat_conflicts;

   always_ff @(posedge clk) begin
      if (!rst) begin
         stat_grants_c0 <= '0;
         stat_grants_c1 <= '0;
         stat_conflicts <= '0;
      end else begin
         if (arb_fire && !winner) stat_grants_c0 <= stat_grants_c0 + 32'd1;
         if (arb_fire &&  winner) stat_grants_c1 <= stat_grants_c1 + 32'd1;
         if (arb_fire && c0_req && c1_req) stat_conflicts <= stat_conflicts + 32'd1;
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: doc/burst_ram_arbiter.md
# burst_ram_arbiter

Two-client arbiter that shares one `BurstRAM` between two cache controllers, for example instruction-side and data-side `CacheData` instances. Each client sees a private copy of the `br_` burst interface plus a request/grant pair. Once a client is granted, it owns the RAM until its burst completes. Arbitration is round-robin and fully registered; RAM-side command signals are muxed combinationally from the owner.

## Interface
- `DEPTH_BITWIDTH`, default 4: RAM burst-address width.
- `DATA_BITWIDTH`, default 64: burst beat width, a multiple of 8.
- `BURST_COUNT`, default 4: beats per burst, ≥2.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `cN_req`  in  1  request for RAM ownership (N = 0, 1); level.
- `cN_gnt`  out  1  ownership granted; registered.
- `cN_cmd`  in  1  0 = read burst, 1 = write burst.
- `cN_cmd_en`  in  1  command strobe; valid only while `cN_gnt`.
- `cN_addr`  in  DEPTH_BITWIDTH  burst address.
- `cN_wr_data`  in  DATA_BITWIDTH  write beat.
- `cN_data_mask`  in  DATA_BITWIDTH/8  byte mask; passed through unmodified.
- `cN_rd_data`  out  DATA_BITWIDTH  read beat; `br_rd_data` broadcast to both clients.
- `cN_rd_data_valid`  out  1  read beat valid; owner only.
- `cN_busy`  out  1  equals `br_busy | !cN_gnt`.
- `br_cmd`, `br_cmd_en`, `br_addr`, `br_wr_data`, `br_data_mask`  out  RAM command side.
- `br_rd_data`, `br_rd_data_valid`, `br_busy`  in  RAM response side.

## Operation
- **RAM contract, read:** `cmd_en` with `cmd=0`, then `BURST_COUNT` cycles with `rd_data_valid`, not necessarily consecutive.
- **RAM contract, write:** `cmd_en` with `cmd=1` and beat 1 in the same cycle, then beats 2..`BURST_COUNT` on the consecutive following cycles.
- **States:**
  - IDLE: no owner, both `gnt`=0.
  - GRANT: owner set, waiting for `cmd_en`.
  - READ: counting valid beats.
  - WRITE: counting remaining beats.
- **IDLE → GRANT:** requires `!br_busy` and at least one `req`.
  - A single requester wins.
  - If both request, the client ≠ `last_owner` wins, and `last_owner` updates to the winner.
- **GRANT:**
  - Owner `cmd_en`=1 → READ (cmd 0) or WRITE (cmd 1); the beat counter clears.
  - Owner `req`=0 without `cmd_en` → IDLE (abort, no RAM access).
- **READ:** count `br_rd_data_valid`. On beat `BURST_COUNT` → IDLE.
- **WRITE:** count cycles. After `BURST_COUNT-1` further beats → IDLE.
- **Muxing:**
  - `br_cmd`, `br_addr`, `br_wr_data` and `br_data_mask` follow the owner, or client 0 when IDLE.
  - `br_cmd_en` = owner `cmd_en` & state==GRANT. `cmd_en` in any other state, or from a non-owner, is ignored.
- **Request lifetime:** `req` deassertion during READ/WRITE does not truncate the burst.
- **Counter width:** beat counter is $clog2(`BURST_COUNT`+1) bits and saturates; no wrap.
- **Reset values:**
  - State IDLE; `last_owner`=1, so client 0 wins the first tie.
  - Both `gnt`, both `rd_data_valid` and `br_cmd_en` are 0; both `busy` are 1.
- **Reset mid-burst:** abandons the burst. The RAM shares `rst`, so there is no residual traffic.

## Timing
- `req` sampled in IDLE at edge N (`br_busy`=0) → `gnt`=1 from N+1.
- Owner may assert `cmd_en` from N+1; it reaches `br_cmd_en` in the same cycle (zero latency).
- Final read beat or final write beat at cycle M → `gnt`=0 and IDLE from M+1.
- Re-arbitration at edge M+1 → earliest next `gnt` at M+2. This is a fixed one-cycle bubble.
- `br_busy`=1 in IDLE blocks grants. In GRANT it only gates the client via `cN_busy`; the client must not strobe while busy.
- `cN_rd_data_valid` = `br_rd_data_valid` & state==READ & owner==N; same cycle, no register.

## Configuration
- Macro `ARBITER_STATS_EN`.
- **Defined:**
  - 32-bit counters `stat_grants_c0` and `stat_grants_c1`, each incrementing on IDLE→GRANT for that client.
  - 32-bit counter `stat_conflicts`, incrementing when both clients request in IDLE with the RAM not busy.
  - Counters reset to 0 and are readable hierarchically by benches.
- **Undefined:** counters absent; functional behaviour identical.

## Test plan
- **Solo read:** c0 `req` alone, read addr 2 → `c0_gnt` next cycle, `br_addr`=2, 4 beats with `c0_rd_data_valid`, `c1_rd_data_valid` stays 0, `c0_gnt`=0 the cycle after beat 4.
- **First tie:** both `req` in the first cycle after reset → c0 granted first, `c1_gnt` exactly 2 cycles after c0's last beat, `stat_conflicts`=1.
- **Fairness:** both `req` held continuously for 4 bursts → grant order c0, c1, c0, c1; `stat_grants_c0`=`stat_grants_c1`=2.
- **Write/read-back:** c1 writes addr 5 beats 0x1, 0x2, 0x3, 0x4 with mask 0; c0 then reads addr 5 → `c0_rd_data` 0x1, 0x2, 0x3, 0x4.
- **Illegal strobe:** c1 `cmd_en`=1 while `c1_gnt`=0 → `br_cmd_en` stays 0, `c1_busy`=1, RAM contents unchanged.
- **Reset mid-burst:** `rst`=0 after read beat 2 → next cycle both `gnt`=0, state IDLE, all stats 0; a fresh c0 read then completes normally.
